apb_slave_mem: RTL and testbench

APB3 completer (slave) holding a small register-file memory; it is the responder end of the bus driven by our APB master/driver interface. It accepts setup/access phases, inserts a programmable number of wait states, and commits writes or returns read data with pready. Out-of-range addresses complete with pslverr. Two instances sit behind the master's slave-select decode.

---
 rtl/apb_slv_pkg.sv | 10 +
 rtl/apb_slv_ram.sv | 24 ++
 rtl/apb_slave_mem.sv | 137 +++++++++++++
 tb/tb_apb_slave_mem.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types for the APB completer memory: FSM state encoding and wait-counter width.
package apb_slv_pkg;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;
endpackage

// File: rtl/apb_slv_ram.sv
// Single-port register-file storage: synchronous write, combinational read.
module apb_slv_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 8,
  parameter int unsigned RAW   = 6
) (
  input  logic           i_clk,
  input  logic           i_we,
  input  logic [RAW-1:0] i_addr,
  input  logic [DW-1:0]  i_wdata,
  output logic [DW-1:0]  o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer fronting a small memory, with programmable wait states and
// pslverr on out-of-range addresses. All bus outputs are registered.
import apb_slv_pkg::*;

module apb_slave_mem #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam int unsigned RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_write, r_err;
  logic [RAW-1:0]   r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_prdata, w_prdata_nxt;
  logic             r_pready, w_pready_nxt;
  logic             r_pslverr, w_pslverr_nxt;

  logic             w_setup, w_err_bus, w_complete;
  logic             w_cmp_write, w_cmp_err, w_ram_we;
  logic [RAW-1:0]   w_ram_addr;
  logic [DW-1:0]    w_ram_rdata;

  assign w_setup   = psel & ~penable;
  assign w_err_bus = (32'(paddr) >= DEPTH);

  // In IDLE the completion (WAIT_CYCLES=0) must use the live bus, since the
  // capture registers load on the same edge.
  assign w_ram_addr  = (r_state == IDLE) ? paddr[RAW-1:0] : r_addr;
  assign w_cmp_write = (r_state == IDLE) ? pwrite : r_write;
  assign w_cmp_err   = (r_state == IDLE) ? w_err_bus : r_err;
  assign w_ram_we    = (r_state == READY) & r_write & ~r_err & ~preset;

  apb_slv_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .RAW   (RAW)
  ) u_ram (
    .i_clk   (pclk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      if ((r_state == IDLE) && w_setup) begin
        r_write <= pwrite;
        r_err   <= w_err_bus;
        r_addr  <= paddr[RAW-1:0];
        r_wdata <= pwdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = READY;
            w_complete  = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = READY;
          w_complete  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      READY:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    if (w_complete) begin
      w_pready_nxt  = 1'b1;
      w_pslverr_nxt = w_cmp_err;
      if (!w_cmp_err && !w_cmp_write) begin
        w_prdata_nxt = w_ram_rdata;
      end
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench: three completers (0, 1 and 3 wait states) on a shared bus,
// each with its own psel; a negedge monitor checks every completion.
module tb_apb_slave_mem;

  logic       pclk = 1'b0;
  logic       preset;
  logic [2:0] psel_v;
  logic       penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] rd  [3];
  logic       rdy [3];
  logic       er  [3];

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       err;
    int         waits;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   wc [3];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(0)) u_wc0 (
    .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(rd[0]), .pready(rdy[0]), .pslverr(er[0]));
  apb_slave_mem #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(1)) u_wc1 (
    .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(rd[1]), .pready(rdy[1]), .pslverr(er[1]));
  apb_slave_mem #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(3)) u_wc3 (
    .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(rd[2]), .pready(rdy[2]), .pslverr(er[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts pready-low access cycles and checks each completion.
  always @(negedge pclk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (preset || !(psel_v[i] && penable)) begin
        wc[i] = 0;
      end else if (rdy[i]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready: inst %0d got pready=1 expected no transfer", i);
        end else begin
          e = q.pop_front();
          chk("inst", i, e.inst);
          chk("pslverr", int'(er[i]), int'(e.err));
          chk("prdata", int'(rd[i]), int'(e.data));
          chk("wait_states", wc[i], e.waits);
        end
        wc[i] = 0;
      end else begin
        wc[i]++;
      end
    end
  end

  task automatic xfer(input int inst, input bit wr, input logic [7:0] addr,
                      input logic [7:0] data, input logic [7:0] exp_rd,
                      input bit exp_err, input int waits);
    bit done;
    exp_t e;
    e.inst = inst; e.data = exp_rd; e.err = exp_err; e.waits = waits;
    q.push_back(e);
    psel_v       = 3'b000;
    psel_v[inst] = 1'b1;
    penable      = 1'b0;
    pwrite       = wr;
    paddr        = addr;
    pwdata       = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = ~addr;   // completer must use the captured values
    pwdata  = ~data;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge pclk);
      if (rdy[inst]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: inst %0d got no pready expected pready within 40 cycles", inst);
    end
    @(posedge pclk); #1;
  endtask

  task automatic idle();
    psel_v  = 3'b000;
    penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  initial begin
    preset = 1'b1; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_pready", int'(rdy[i]), 0);
      chk("reset_pslverr", int'(er[i]), 0);
      chk("reset_prdata", int'(rd[i]), 0);
    end
    preset = 1'b0;
    idle();

    // WAIT_CYCLES=1: basic write/read, boundary address, out-of-range
    xfer(1, 1, 8'h10, 8'hA5, 8'h00, 0, 1);
    xfer(1, 0, 8'h10, 8'h00, 8'hA5, 0, 1);
    xfer(1, 1, 8'h00, 8'h99, 8'h00, 0, 1);
    xfer(1, 1, 8'h40, 8'h3C, 8'h00, 1, 1);
    xfer(1, 0, 8'h00, 8'h00, 8'h99, 0, 1);
    xfer(1, 0, 8'hFF, 8'h00, 8'h00, 1, 1);
    xfer(1, 1, 8'h3F, 8'h42, 8'h00, 0, 1);
    xfer(1, 0, 8'h3F, 8'h00, 8'h42, 0, 1);
    idle();

    // Back-to-back, no idle cycles between transfers
    xfer(1, 1, 8'h01, 8'h11, 8'h00, 0, 1);
    xfer(1, 1, 8'h02, 8'h22, 8'h00, 0, 1);
    xfer(1, 1, 8'h03, 8'h33, 8'h00, 0, 1);
    xfer(1, 0, 8'h01, 8'h00, 8'h11, 0, 1);
    xfer(1, 0, 8'h02, 8'h00, 8'h22, 0, 1);
    xfer(1, 0, 8'h03, 8'h00, 8'h33, 0, 1);
    xfer(1, 1, 8'h04, 8'h44, 8'h00, 0, 1);
    xfer(1, 0, 8'h04, 8'h00, 8'h44, 0, 1);
    idle();

    // WAIT_CYCLES=0 and 3
    xfer(0, 1, 8'h20, 8'h5A, 8'h00, 0, 0);
    xfer(0, 0, 8'h20, 8'h00, 8'h5A, 0, 0);
    xfer(0, 0, 8'h80, 8'h00, 8'h00, 1, 0);
    xfer(2, 1, 8'h05, 8'hC3, 8'h00, 0, 3);
    xfer(2, 0, 8'h05, 8'h00, 8'hC3, 0, 3);
    idle();

    // Abort: psel dropped during WAIT of a write to 0x05
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'hEE;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk); chk("abort_pready_a1", int'(rdy[2]), 0);
    @(posedge pclk); #1;
    @(negedge pclk); chk("abort_pready_a2", int'(rdy[2]), 0);
    @(posedge pclk); #1;
    psel_v = 3'b000; penable = 1'b0;
    @(negedge pclk); chk("abort_pready_idle", int'(rdy[2]), 0);
    @(posedge pclk); #1;
    @(negedge pclk); chk("abort_pready_late", int'(rdy[2]), 0);
    @(posedge pclk); #1;
    xfer(2, 0, 8'h05, 8'h00, 8'hC3, 0, 3);
    idle();

    // Reset for 2 cycles in the middle of a read
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    chk("midreset_pready", int'(rdy[2]), 0);
    chk("midreset_pslverr", int'(er[2]), 0);
    chk("midreset_prdata", int'(rd[2]), 0);
    preset = 1'b0; psel_v = 3'b000; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(2, 0, 8'h05, 8'h00, 8'hC3, 0, 3);
    idle();

    // Reset on the completion edge of a write drops the write
    psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h77;
    @(posedge pclk); #1;
    chk("drop_pready_before_reset", int'(rdy[0]), 1);
    preset = 1'b1; psel_v = 3'b000;
    @(posedge pclk); #1;
    preset = 1'b0;
    chk("drop_pready_after_reset", int'(rdy[0]), 0);
    xfer(0, 0, 8'h20, 8'h00, 8'h5A, 0, 0);
    idle();

    repeat (2) @(posedge pclk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
